// File: rtl/zbuf_pkg.sv
// Shared types and helpers for the depth-tested framebuffer.
package zbuf_pkg;

   typedef enum logic {
      ZB_CLEAR = 1'b0,
      ZB_RUN   = 1'b1
   } zb_state_e;

   // Address width for a buffer of npix entries (never narrower than 1 bit).
   function automatic int unsigned zb_addr_w(input int unsigned npix);
      return (npix > 1) ? $clog2(npix) : 1;
   endfunction

endpackage

// File: rtl/zbuf_ram.sv
// Simple dual-port memory: one write port, one registered read port (read-first).
module zbuf_ram #(
   parameter int unsigned DW    = 16,
   parameter int unsigned DEPTH = 16,
   parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem_q [DEPTH];
   logic [DW-1:0] rd_q;

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   // Output register resets; the array itself is never reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_q <= '0;
      else        rd_q <= mem_q[raddr];
   end

   assign rdata = rd_q;

endmodule

// File: rtl/zbuf_framebuffer.sv
// Depth-tested framebuffer: clear sweep, 3-stage read-compare-write pipeline
// with same-pixel forwarding, bounds rejection and saturating statistics.
module zbuf_framebuffer
   import zbuf_pkg::*;
#(
   parameter int unsigned        HRES        = 320,
   parameter int unsigned        VRES        = 180,
   parameter int unsigned        Z_W         = 16,
   parameter int unsigned        COLOR_W     = 16,
   parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0,
   parameter int unsigned        STAT_W      = 16
) (
   input  logic                          clk_in,
   input  logic                          rst_in,
   input  logic                          clear_in,
   input  logic                          valid_in,
   output logic                          rdy_out,
   input  logic [$clog2(HRES)-1:0]       x_in,
   input  logic [$clog2(VRES)-1:0]       y_in,
   input  logic [Z_W-1:0]                z_in,
   input  logic [COLOR_W-1:0]            color_in,
   input  logic [$clog2(HRES*VRES)-1:0]  rd_addr_in,
   output logic [COLOR_W-1:0]            rd_data_out,
   output logic                          busy_out,
   output logic [STAT_W-1:0]             pass_count_out,
   output logic [STAT_W-1:0]             fail_count_out
);

   localparam int unsigned NPIX   = HRES * VRES;
   localparam int unsigned ADDR_W = zb_addr_w(NPIX);
   localparam int unsigned XW1    = $clog2(HRES) + 1;
   localparam int unsigned YW1    = $clog2(VRES) + 1;
   localparam int unsigned SUM_W  = STAT_W + 1;
   localparam logic [Z_W-1:0]    DEPTH_MAX = '1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NPIX - 1);

   typedef struct packed {
      logic [ADDR_W-1:0]  addr;
      logic [Z_W-1:0]     z;
      logic [COLOR_W-1:0] color;
      logic               valid;
   } frag_t;

   zb_state_e           state_q, state_d;
   logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
   logic                pend_q, pend_d;
   logic                rdy_q, rdy_d;
   logic                busy_q, busy_d;
   frag_t               s1_q, s1_d;
   frag_t               s2_q, s2_d;
   logic                fwd_q, fwd_d;
   logic [Z_W-1:0]      fwd_z_q, fwd_z_d;
   logic                oob_q, oob_d;
   logic [STAT_W-1:0]   pass_cnt_q, pass_cnt_d;
   logic [STAT_W-1:0]   fail_cnt_q, fail_cnt_d;

   logic                accept_c;
   logic                in_bounds_c;
   logic [ADDR_W-1:0]   addr0_c;
   logic [Z_W-1:0]      depth_rd;
   logic [Z_W-1:0]      stored_z_c;
   logic                pass_c;
   logic                reject_c;
   logic                clearing_c;
   logic                mem_we_c;
   logic [ADDR_W-1:0]   mem_waddr_c;
   logic [Z_W-1:0]      depth_wdata_c;
   logic [COLOR_W-1:0]  color_wdata_c;
   logic [1:0]          fail_inc_c;
   logic [SUM_W-1:0]    fail_sum_c;

   // Stage 0 bounds check and linear address; stage 2 depth test.
   always_comb begin
      accept_c    = valid_in && rdy_q;
      in_bounds_c = (XW1'(x_in) < XW1'(HRES)) && (YW1'(y_in) < YW1'(VRES));
      addr0_c     = ADDR_W'(y_in) * ADDR_W'(HRES) + ADDR_W'(x_in);
      stored_z_c  = fwd_q ? fwd_z_q : depth_rd;
      pass_c      = s2_q.valid && (s2_q.z < stored_z_c);
      reject_c    = s2_q.valid && !pass_c;
      clearing_c  = (state_q == ZB_CLEAR);
   end

   // Shared write port for both buffers: clear sweep or passing fragment.
   always_comb begin
      mem_we_c      = clearing_c || pass_c;
      mem_waddr_c   = clearing_c ? clr_addr_q : s2_q.addr;
      depth_wdata_c = clearing_c ? DEPTH_MAX : s2_q.z;
      color_wdata_c = clearing_c ? CLEAR_COLOR : s2_q.color;
   end

   // Next-state, pipeline advance and registered outputs.
   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      pend_d     = pend_q;

      s1_d.addr  = addr0_c;
      s1_d.z     = z_in;
      s1_d.color = color_in;
      s1_d.valid = accept_c && in_bounds_c;
      s2_d       = s1_q;
      oob_d      = accept_c && !in_bounds_c;

      // Fragment now in stage 1 read the depth RAM while stage 2 wrote the same pixel.
      fwd_d   = pass_c && s1_q.valid && (s1_q.addr == s2_q.addr);
      fwd_z_d = s2_q.z;

      case (state_q)
         ZB_CLEAR: begin
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (clr_addr_q == LAST_ADDR) begin
               state_d    = ZB_RUN;
               clr_addr_d = '0;
            end
         end
         ZB_RUN: begin
            if (clear_in) pend_d = 1'b1;
            if (pend_q && !s1_q.valid && !s2_q.valid) begin
               state_d    = ZB_CLEAR;
               pend_d     = 1'b0;
               clr_addr_d = '0;
            end
         end
         default: state_d = ZB_CLEAR;
      endcase

      rdy_d  = (state_d == ZB_RUN) && !pend_d;
      busy_d = (state_d == ZB_CLEAR) || pend_d || s1_d.valid || s2_d.valid || oob_d;

      pass_cnt_d = (pass_c && (pass_cnt_q != '1)) ? pass_cnt_q + STAT_W'(1) : pass_cnt_q;

      // Depth reject and an out-of-bounds reject can land in the same cycle.
      fail_inc_c = 2'(reject_c) + 2'(oob_q);
      fail_sum_c = SUM_W'(fail_cnt_q) + SUM_W'(fail_inc_c);
      fail_cnt_d = fail_sum_c[STAT_W] ? '1 : fail_sum_c[STAT_W-1:0];
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q    <= ZB_CLEAR;
         clr_addr_q <= '0;
         pend_q     <= 1'b0;
         rdy_q      <= 1'b0;
         busy_q     <= 1'b1;
         s1_q       <= '0;
         s2_q       <= '0;
         fwd_q      <= 1'b0;
         fwd_z_q    <= '0;
         oob_q      <= 1'b0;
         pass_cnt_q <= '0;
         fail_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
         pend_q     <= pend_d;
         rdy_q      <= rdy_d;
         busy_q     <= busy_d;
         s1_q       <= s1_d;
         s2_q       <= s2_d;
         fwd_q      <= fwd_d;
         fwd_z_q    <= fwd_z_d;
         oob_q      <= oob_d;
         pass_cnt_q <= pass_cnt_d;
         fail_cnt_q <= fail_cnt_d;
      end
   end

   zbuf_ram #(.DW(Z_W), .DEPTH(NPIX), .AW(ADDR_W)) u_depth (
      .clk   (clk_in),
      .rst_n (rst_in),
      .we    (mem_we_c),
      .waddr (mem_waddr_c),
      .wdata (depth_wdata_c),
      .raddr (s1_q.addr),
      .rdata (depth_rd)
   );

   zbuf_ram #(.DW(COLOR_W), .DEPTH(NPIX), .AW(ADDR_W)) u_color (
      .clk   (clk_in),
      .rst_n (rst_in),
      .we    (mem_we_c),
      .waddr (mem_waddr_c),
      .wdata (color_wdata_c),
      .raddr (rd_addr_in),
      .rdata (rd_data_out)
   );

   assign rdy_out        = rdy_q;
   assign busy_out       = busy_q;
   assign pass_count_out = pass_cnt_q;
   assign fail_count_out = fail_cnt_q;

endmodule

// File: tb/tb_zbuf_framebuffer.sv
// Bench for zbuf_framebuffer: directed scenarios plus random fragments against a serial pixel model.
module tb_zbuf_framebuffer;

   localparam int unsigned HRES    = 6;
   localparam int unsigned VRES    = 5;
   localparam int unsigned Z_W     = 8;
   localparam int unsigned COLOR_W = 16;
   localparam int unsigned STAT_W  = 4;
   localparam int unsigned NPIX    = HRES * VRES;
   localparam int unsigned XW      = $clog2(HRES);
   localparam int unsigned YW      = $clog2(VRES);
   localparam int unsigned AW      = $clog2(NPIX);
   localparam logic [COLOR_W-1:0] CLR_C = 16'h1234;
   localparam int ZMAX = (1 << Z_W) - 1;
   localparam int SAT  = (1 << STAT_W) - 1;

   logic                clk_in = 1'b0;
   logic                rst_in;
   logic                clear_in;
   logic                valid_in;
   logic                rdy_out;
   logic [XW-1:0]       x_in;
   logic [YW-1:0]       y_in;
   logic [Z_W-1:0]      z_in;
   logic [COLOR_W-1:0]  color_in;
   logic [AW-1:0]       rd_addr_in;
   logic [COLOR_W-1:0]  rd_data_out;
   logic                busy_out;
   logic [STAT_W-1:0]   pass_count_out;
   logic [STAT_W-1:0]   fail_count_out;

   int n_cmp  = 0;
   int n_fail = 0;
   int zm [NPIX];
   int cm [NPIX];
   int m_pass = 0;
   int m_fail = 0;

   always #5 clk_in = ~clk_in;

   zbuf_framebuffer #(
      .HRES(HRES), .VRES(VRES), .Z_W(Z_W), .COLOR_W(COLOR_W),
      .CLEAR_COLOR(CLR_C), .STAT_W(STAT_W)
   ) dut (
      .clk_in         (clk_in),
      .rst_in         (rst_in),
      .clear_in       (clear_in),
      .valid_in       (valid_in),
      .rdy_out        (rdy_out),
      .x_in           (x_in),
      .y_in           (y_in),
      .z_in           (z_in),
      .color_in       (color_in),
      .rd_addr_in     (rd_addr_in),
      .rd_data_out    (rd_data_out),
      .busy_out       (busy_out),
      .pass_count_out (pass_count_out),
      .fail_count_out (fail_count_out)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference: every fragment resolved in acceptance order, one at a time.
   task automatic model_frag(input int x, input int y, input int z, input int c);
      int a;
      if (x < HRES && y < VRES) begin
         a = y * HRES + x;
         if (z < zm[a]) begin
            zm[a] = z;
            cm[a] = c;
            if (m_pass < SAT) m_pass++;
         end else if (m_fail < SAT) m_fail++;
      end else if (m_fail < SAT) m_fail++;
   endtask

   task automatic model_clear();
      for (int a = 0; a < NPIX; a++) begin
         zm[a] = ZMAX;
         cm[a] = int'(CLR_C);
      end
   endtask

   task automatic send(input int x, input int y, input int z, input int c);
      int n = 0;
      x_in = XW'(x); y_in = YW'(y); z_in = Z_W'(z); color_in = COLOR_W'(c);
      valid_in = 1'b1;
      while (rdy_out !== 1'b1 && n < 2000) begin
         @(posedge clk_in); #1;
         n++;
      end
      if (n >= 2000) check("accept_timeout", 32'(rdy_out), 32'd1);
      else model_frag(x, y, z, c);
      @(posedge clk_in); #1;
      valid_in = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy_out !== 1'b0 && n < 500) begin
         @(posedge clk_in); #1;
         n++;
      end
      check("drain", 32'(busy_out), 32'd0);
   endtask

   task automatic read_px(input int a, output logic [COLOR_W-1:0] d);
      rd_addr_in = AW'(a);
      @(posedge clk_in); #1;
      d = rd_data_out;
   endtask

   task automatic check_all(input string tag);
      logic [COLOR_W-1:0] d;
      for (int a = 0; a < NPIX; a++) begin
         read_px(a, d);
         check($sformatf("%s[%0d]", tag, a), 32'(d), 32'(cm[a]));
      end
   endtask

   task automatic check_cnt(input string tag);
      check({tag, "_pass"}, 32'(pass_count_out), 32'(m_pass));
      check({tag, "_fail"}, 32'(fail_count_out), 32'(m_fail));
   endtask

   // Edges until rdy_out is seen high; optional clear_in poke mid-wait.
   task automatic count_rdy_low(output int n, input bit poke);
      n = 0;
      do begin
         if (poke && n == 10) clear_in = 1'b1;
         @(posedge clk_in); #1;
         clear_in = 1'b0;
         n++;
      end while (rdy_out !== 1'b1 && n < 2000);
   endtask

   initial begin
      int n;
      int rx, ry;
      logic [COLOR_W-1:0] d;

      rst_in = 1'b0; clear_in = 1'b0; valid_in = 1'b0;
      x_in = '0; y_in = '0; z_in = '0; color_in = '0; rd_addr_in = '0;
      model_clear();

      repeat (3) @(posedge clk_in);
      #1;
      check("rst_rdy",  32'(rdy_out), 32'd0);
      check("rst_busy", 32'(busy_out), 32'd1);
      check("rst_rd",   32'(rd_data_out), 32'd0);
      check("rst_pass", 32'(pass_count_out), 32'd0);
      check("rst_fail", 32'(fail_count_out), 32'd0);

      rst_in = 1'b1;
      count_rdy_low(n, 1'b0);
      check("sweep_len", 32'(n), 32'(NPIX));
      check("idle_busy", 32'(busy_out), 32'd0);
      check_all("clear_px");

      // Nearer then farther at pixel (3,2).
      send(3, 2, 100, 16'hF800);
      send(3, 2, 200, 16'h07E0);
      wait_idle();
      read_px(2 * HRES + 3, d);
      check("px32", 32'(d), 32'hF800);
      check("d1_pass", 32'(pass_count_out), 32'd1);
      check("d1_fail", 32'(fail_count_out), 32'd1);

      // Back-to-back same pixel, exercises forwarding.
      send(1, 1, 50, 16'h0101);
      send(1, 1, 40, 16'h0202);
      send(1, 1, 45, 16'h0303);
      wait_idle();
      read_px(1 * HRES + 1, d);
      check("px11", 32'(d), 32'h0202);
      check("d2_pass", 32'(pass_count_out), 32'd3);
      check("d2_fail", 32'(fail_count_out), 32'd2);

      // Out-of-bounds fragments.
      send(HRES, 0, 1, 16'hDEAD);
      check("oob_rdy", 32'(rdy_out), 32'd1);
      send(0, VRES, 1, 16'hBEEF);
      send(7, 7, 1, 16'hCAFE);
      check("oob_rdy2", 32'(rdy_out), 32'd1);
      wait_idle();
      check("d3_fail", 32'(fail_count_out), 32'd5);
      check_all("oob_px");

      // Equal depth is rejected.
      send(3, 2, 100, 16'h5555);
      wait_idle();
      read_px(2 * HRES + 3, d);
      check("eq_px", 32'(d), 32'hF800);
      check("eq_fail", 32'(fail_count_out), 32'd6);
      check_cnt("eq");

      // Clear with two fragments in flight; a second clear_in mid-sweep is ignored.
      send(0, 0, 10, 16'hAAAA);
      send(0, 0, 5, 16'hBBBB);
      clear_in = 1'b1;
      model_clear();
      count_rdy_low(n, 1'b1);
      check("clr_len", 32'(n), 32'(NPIX + 3));
      check("clr_pass", 32'(pass_count_out), 32'd5);
      check("clr_fail", 32'(fail_count_out), 32'd6);
      check("clr_busy", 32'(busy_out), 32'd0);
      check_all("clr_px");

      // Random traffic with pixel repeats, gaps and out-of-bounds coordinates.
      rx = 0; ry = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk_in); #1;
         end
         if ($urandom_range(0, 2) != 0) begin
            rx = $urandom_range(0, HRES);
            ry = $urandom_range(0, VRES);
         end
         send(rx, ry, $urandom_range(0, ZMAX), $urandom_range(0, 16'hFFFF));
         if (i % 100 == 99) begin
            wait_idle();
            check_cnt("rnd");
            check_all("rnd_px");
         end
      end

      // Reset with fragments in flight: discarded, sweep restarts, counters cleared.
      send(2, 2, 1, 16'h7777);
      send(4, 1, 1, 16'h8888);
      rst_in = 1'b0;
      #2;
      check("mid_rst_rdy",  32'(rdy_out), 32'd0);
      check("mid_rst_busy", 32'(busy_out), 32'd1);
      check("mid_rst_pass", 32'(pass_count_out), 32'd0);
      @(posedge clk_in); #1;
      rst_in = 1'b1;
      model_clear();
      m_pass = 0; m_fail = 0;
      count_rdy_low(n, 1'b0);
      check("mid_rst_sweep", 32'(n), 32'(NPIX));
      check_cnt("mid_rst");
      check_all("mid_rst_px");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
